fft_x4_sched: RTL and testbench

- Scheduler that shares one 4-point FFT engine among NREQ requesters; the engine is non-pipelined and takes one op at a time (valid in, complete out).
- Arbitrates requests round-robin, launches one engine op, waits for engine complete with a timeout watchdog, and returns the result to the granted requester with backpressure.
- Sits between OFDM symbol-level blocks and the shared x4 butterfly engine.

---
 rtl/fft_x4_sched.sv | 180 ++++++++++++++++++
 tb/tb_fft_x4_sched.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_x4_sched.sv
// fft_x4_sched: shares one non-pipelined 4-point FFT engine among NREQ
// requesters using round-robin grant, a WAIT watchdog and backpressured return.
module fft_x4_sched #(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*4*DATA_W-1:0] req_data_i,
    input  logic [NREQ*4*DATA_W-1:0] req_data_q,
    output logic [NREQ-1:0]          rsp_valid,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [4*DATA_W-1:0]      rsp_data_i,
    output logic [4*DATA_W-1:0]      rsp_data_q,
    output logic                     eng_valid,
    output logic [4*DATA_W-1:0]      eng_data_i,
    output logic [4*DATA_W-1:0]      eng_data_q,
    input  logic                     eng_complete,
    input  logic [4*DATA_W-1:0]      eng_out_i,
    input  logic [4*DATA_W-1:0]      eng_out_q,
    input  logic                     err_clr,
    output logic                     err_timeout,
    output logic [15:0]              op_count,
    output logic [1:0]               state_sched
);

    localparam int SW = 4 * DATA_W;
    localparam int PW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gnt;
    logic [PW-1:0] pick;
    logic          pick_ok;
    logic [PW:0]   scan_idx;
    logic [TW-1:0] timer;
    logic [SW-1:0] op_i;
    logic [SW-1:0] op_q;
    logic [SW-1:0] res_i;
    logic [SW-1:0] res_q;
    logic          err;
    logic [15:0]   cnt;
    logic          take;
    logic          timeout_hit;
    logic          complete_hit;
    logic          rsp_fire;

    // Round-robin search: first pending requester at or after rr_ptr.
    always_comb begin
        pick     = '0;
        pick_ok  = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = {1'b0, rr_ptr} + (PW+1)'(i);
            if (scan_idx >= (PW+1)'(NREQ)) begin
                scan_idx = scan_idx - (PW+1)'(NREQ);
            end
            if (!pick_ok && req_valid[scan_idx[PW-1:0]]) begin
                pick_ok = 1'b1;
                pick    = scan_idx[PW-1:0];
            end
        end
    end

    // Next-state and handshake decode; accept is held off while in reset.
    always_comb begin
        state_nxt    = state;
        req_ready    = '0;
        rsp_valid    = '0;
        eng_valid    = 1'b0;
        take         = 1'b0;
        timeout_hit  = 1'b0;
        complete_hit = 1'b0;
        rsp_fire     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_ok && !reset) begin
                    req_ready[pick] = 1'b1;
                    take            = 1'b1;
                    state_nxt       = ISSUE;
                end
            end
            ISSUE: begin
                eng_valid = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (eng_complete) begin
                    complete_hit = 1'b1;
                    state_nxt    = DELIVER;
                end else if (timer == TIMER_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            DELIVER: begin
                rsp_valid[gnt] = 1'b1;
                if (rsp_ready[gnt]) begin
                    rsp_fire  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, grant pointer, watchdog timer and status counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            gnt    <= '0;
            timer  <= '0;
            err    <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                gnt    <= pick;
                rr_ptr <= (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;
            end
            if (state == ISSUE) begin
                timer <= '0;
            end else if (state == WAIT) begin
                timer <= timer + 1'b1;
            end
            if (timeout_hit) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
            if (rsp_fire) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    // Operand and result capture; samples pass through untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_i  <= '0;
            op_q  <= '0;
            res_i <= '0;
            res_q <= '0;
        end else begin
            if (take) begin
                op_i <= req_data_i[pick*SW +: SW];
                op_q <= req_data_q[pick*SW +: SW];
            end
            if (complete_hit) begin
                res_i <= eng_out_i;
                res_q <= eng_out_q;
            end
        end
    end

    assign eng_data_i  = op_i;
    assign eng_data_q  = op_q;
    assign rsp_data_i  = res_i;
    assign rsp_data_q  = res_q;
    assign err_timeout = err;
    assign op_count    = cnt;
    assign state_sched = state;

endmodule

// File: tb/tb_fft_x4_sched.sv
// tb_fft_x4_sched: scheduler bench with a 4-point DFT engine model and a
// transaction-level reference checked on every cycle.
module tb_fft_x4_sched;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int TO   = 8;
    localparam int SW   = 4 * DW;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*SW-1:0]  req_data_i;
    logic [NREQ*SW-1:0]  req_data_q;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [SW-1:0]       rsp_data_i;
    logic [SW-1:0]       rsp_data_q;
    logic                eng_valid;
    logic [SW-1:0]       eng_data_i;
    logic [SW-1:0]       eng_data_q;
    logic                eng_complete;
    logic [SW-1:0]       eng_out_i;
    logic [SW-1:0]       eng_out_q;
    logic                err_clr;
    logic                err_timeout;
    logic [15:0]         op_count;
    logic [1:0]          state_sched;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    fft_x4_sched #(.NREQ(NREQ), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data_i(req_data_i),
        .req_data_q(req_data_q),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data_i(rsp_data_i),
        .rsp_data_q(rsp_data_q),
        .eng_valid(eng_valid),
        .eng_data_i(eng_data_i),
        .eng_data_q(eng_data_q),
        .eng_complete(eng_complete),
        .eng_out_i(eng_out_i),
        .eng_out_q(eng_out_q),
        .err_clr(err_clr),
        .err_timeout(err_timeout),
        .op_count(op_count),
        .state_sched(state_sched)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Plain 4-point DFT on signed samples; result packed as {q, i}.
    function automatic logic [2*SW-1:0] dft4(input logic [SW-1:0] xi,
                                              input logic [SW-1:0] xq);
        int r[4];
        int m[4];
        int yr[4];
        int yi[4];
        logic [SW-1:0] oi;
        logic [SW-1:0] oq;
        for (int k = 0; k < 4; k++) begin
            r[k] = int'($signed(xi[k*DW +: DW]));
            m[k] = int'($signed(xq[k*DW +: DW]));
        end
        yr[0] = r[0] + r[1] + r[2] + r[3];
        yi[0] = m[0] + m[1] + m[2] + m[3];
        yr[1] = (r[0] - r[2]) + (m[1] - m[3]);
        yi[1] = (m[0] - m[2]) - (r[1] - r[3]);
        yr[2] = r[0] - r[1] + r[2] - r[3];
        yi[2] = m[0] - m[1] + m[2] - m[3];
        yr[3] = (r[0] - r[2]) - (m[1] - m[3]);
        yi[3] = (m[0] - m[2]) + (r[1] - r[3]);
        for (int k = 0; k < 4; k++) begin
            oi[k*DW +: DW] = DW'(yr[k]);
            oq[k*DW +: DW] = DW'(yi[k]);
        end
        return {oq, oi};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h",
                     nm, cyc, act, exp);
        end
    endtask

    // Engine model: latches operands on launch, completes eng_k cycles later.
    int   eng_k = 2;
    int   eng_cnt = 0;
    logic late_pulse = 1'b0;

    always @(negedge clk) begin
        if (eng_valid === 1'b1) begin
            {eng_out_q, eng_out_i} = dft4(eng_data_i, eng_data_q);
            eng_cnt = eng_k;
        end
    end

    always @(posedge clk) begin
        #1;
        if (eng_cnt > 0) begin
            eng_cnt--;
            eng_complete = (eng_cnt == 0);
        end else begin
            eng_complete = late_pulse;
            late_pulse = 1'b0;
        end
    end

    // Reference: which requester owns the engine, what it must return.
    int            m_st = 0;
    int            m_rr = 0;
    int            m_g = 0;
    int            m_w = 0;
    int            m_cnt = 0;
    logic          m_err = 1'b0;
    logic [SW-1:0] m_op_i = '0;
    logic [SW-1:0] m_op_q = '0;
    logic [SW-1:0] m_res_i = '0;
    logic [SW-1:0] m_res_q = '0;

    always @(negedge clk) begin
        logic [NREQ-1:0] e_rdy;
        logic [NREQ-1:0] e_rsp;
        int              pk;
        logic            set_err;
        pk = -1;
        set_err = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pk < 0 && req_valid[(m_rr + i) % NREQ]) pk = (m_rr + i) % NREQ;
        end
        e_rdy = '0;
        e_rsp = '0;
        if (m_st == 0 && pk >= 0 && !reset) e_rdy[pk] = 1'b1;
        if (m_st == 3) e_rsp[m_g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(e_rdy));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
        chk("eng_valid", 64'(eng_valid), 64'(m_st == 1));
        chk("eng_data_i", eng_data_i, m_op_i);
        chk("eng_data_q", eng_data_q, m_op_q);
        chk("rsp_data_i", rsp_data_i, m_res_i);
        chk("rsp_data_q", rsp_data_q, m_res_q);
        chk("err_timeout", 64'(err_timeout), 64'(m_err));
        chk("op_count", 64'(op_count), 64'(m_cnt));
        chk("state_sched", 64'(state_sched), 64'(m_st));
        if (reset) begin
            m_st = 0; m_rr = 0; m_g = 0; m_w = 0; m_cnt = 0; m_err = 1'b0;
            m_op_i = '0; m_op_q = '0; m_res_i = '0; m_res_q = '0;
        end else begin
            case (m_st)
                0: if (pk >= 0) begin
                    m_g = pk;
                    m_op_i = req_data_i[pk*SW +: SW];
                    m_op_q = req_data_q[pk*SW +: SW];
                    m_rr = (pk + 1) % NREQ;
                    m_st = 1;
                end
                1: begin
                    m_w = 0;
                    m_st = 2;
                end
                2: begin
                    m_w++;
                    if (eng_complete) begin
                        {m_res_q, m_res_i} = dft4(m_op_i, m_op_q);
                        m_st = 3;
                    end else if (m_w == TO) begin
                        set_err = 1'b1;
                        m_st = 0;
                    end
                end
                default: if (rsp_ready[m_g]) begin
                    m_cnt = (m_cnt + 1) % 65536;
                    m_st = 0;
                end
            endcase
            if (set_err) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int w = 0; w < NREQ * SW / 32; w++) begin
            req_data_i[w*32 +: 32] = $urandom;
            req_data_q[w*32 +: 32] = $urandom;
        end
    endtask

    task automatic wait_ready(output int g, output int t);
        g = -1;
        t = 0;
        for (int n = 0; n < 60 && g < 0; n++) begin
            @(negedge clk);
            for (int b = 0; b < NREQ; b++) begin
                if (req_ready[b] === 1'b1 && g < 0) begin
                    g = b;
                    t = cyc;
                end
            end
        end
        if (g < 0) chk("wait_ready_bound", 64'd0, 64'd1);
    endtask

    task automatic wait_rsp(output int t);
        t = -1;
        for (int n = 0; n < 60 && t < 0; n++) begin
            @(negedge clk);
            if (rsp_valid != '0) t = cyc;
        end
        if (t < 0) chk("wait_rsp_bound", 64'd0, 64'd1);
    endtask

    initial begin
        int g;
        int t;
        int t0;
        int tp;
        int order[5];
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        reset = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        err_clr = 1'b0;
        req_data_i = '0;
        req_data_q = '0;
        eng_complete = 1'b0;
        eng_out_i = '0;
        eng_out_q = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_state", 64'(state_sched), 64'd0);
        chk("reset_op_count", 64'(op_count), 64'd0);
        chk("reset_err", 64'(err_timeout), 64'd0);

        // Single op, requester 1, engine latency 2.
        tick();
        eng_k = 2;
        req_data_i[1*SW +: SW] = {16'd4, 16'd3, 16'd2, 16'd1};
        req_valid = 4'b0010;
        wait_ready(g, t);
        chk("single_grant", 64'(g), 64'd1);
        tick();
        req_valid = '0;
        wait_rsp(t0);
        chk("single_latency", 64'(t0 - t), 64'd4);
        chk("single_rsp_valid", 64'(rsp_valid), 64'b0010);
        chk("single_rsp_i", rsp_data_i, 64'hFFFE_FFFE_FFFE_000A);
        chk("single_rsp_q", rsp_data_q, 64'hFFFE_0000_0002_0000);
        @(negedge clk);
        chk("single_op_count", 64'(op_count), 64'd1);

        // Contention from reset, all four requesters always pending.
        tick();
        reset = 1'b1;
        req_valid = 4'hF;
        eng_k = 1;
        rand_data();
        tick();
        reset = 1'b0;
        tp = 0;
        for (int i = 0; i < 5; i++) begin
            wait_ready(g, t);
            chk("contend_order", 64'(g), 64'(order[i]));
            if (i > 0) chk("contend_gap", 64'(t - tp), 64'd4);
            tp = t;
            tick();
            rand_data();
        end
        req_valid = '0;
        repeat (4) tick();
        chk("contend_op_count", 64'(op_count), 64'd5);

        // Backpressure on requester 2 with others pending.
        eng_k = 3;
        rsp_ready = 4'b1011;
        req_valid = 4'b0100;
        rand_data();
        wait_ready(g, t);
        chk("bp_grant", 64'(g), 64'd2);
        tick();
        req_valid = 4'hF;
        wait_rsp(t0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", 64'(rsp_valid), 64'b0100);
        end
        tick();
        rsp_ready = 4'b0100;
        req_valid = '0;
        @(negedge clk);
        chk("bp_handshake_state", 64'(state_sched), 64'd3);
        @(negedge clk);
        chk("bp_idle_after", 64'(state_sched), 64'd0);
        chk("bp_op_count", 64'(op_count), 64'd6);

        // Timeout: engine never completes.
        tick();
        rsp_ready = '1;
        eng_k = 0;
        req_valid = 4'b1000;
        wait_ready(g, t);
        tick();
        req_valid = '0;
        t0 = -1;
        for (int n = 0; n < 30 && t0 < 0; n++) begin
            @(negedge clk);
            if (err_timeout === 1'b1) t0 = cyc;
        end
        // Launch at t+1, eight WAIT cycles, flag visible right after them.
        chk("to_latency", 64'(t0 - t), 64'd10);
        chk("to_state", 64'(state_sched), 64'd0);
        late_pulse = 1'b1;
        @(negedge clk);
        chk("late_complete_state", 64'(state_sched), 64'd0);
        chk("late_complete_rsp", 64'(rsp_valid), 64'd0);
        tick();
        eng_k = 1;
        req_valid = 4'b0001;
        wait_ready(g, t);
        chk("after_to_grant", 64'(g), 64'd0);
        tick();
        req_valid = '0;
        wait_rsp(t0);
        chk("after_to_rsp", 64'(rsp_valid), 64'b0001);
        chk("err_sticky", 64'(err_timeout), 64'd1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_cleared", 64'(err_timeout), 64'd0);

        // Completion on the last WAIT cycle.
        tick();
        eng_k = TO;
        req_valid = 4'b0010;
        wait_ready(g, t);
        tick();
        req_valid = '0;
        wait_rsp(t0);
        chk("edge_latency", 64'(t0 - t), 64'(TO + 2));
        chk("edge_err", 64'(err_timeout), 64'd0);

        // Reset while waiting on the engine.
        tick();
        eng_k = 5;
        req_valid = 4'b0100;
        wait_ready(g, t);
        tick();
        req_valid = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_wait_state", 64'(state_sched), 64'd0);
        chk("rst_wait_eng_valid", 64'(eng_valid), 64'd0);
        chk("rst_wait_eng_data", eng_data_i, 64'd0);
        chk("rst_wait_rsp_data", rsp_data_i, 64'd0);
        chk("rst_wait_op_count", 64'(op_count), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_wait_no_rsp", 64'(rsp_valid), 64'd0);
        end
        tick();
        eng_k = 1;
        req_valid = 4'hF;
        wait_ready(g, t);
        chk("rst_rr_restart", 64'(g), 64'd0);
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Randomized traffic against the reference.
        for (int c = 0; c < 500; c++) begin
            tick();
            req_valid = NREQ'($urandom);
            rsp_ready = NREQ'($urandom);
            err_clr = ($urandom_range(0, 15) == 0);
            eng_k = $urandom_range(1, TO + 1);
            rand_data();
        end
        tick();
        req_valid = '0;
        rsp_ready = '1;
        err_clr = 1'b0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
